// File: rtl/hazard_fwd_ctrl.sv
// Purpose: unified hazard detection and forwarding control for the 5-stage MIPS pipe
//          (load-use/branch stalls, EX/ID forwarding selects, IF flush, memory freeze).
// Latency: all control outputs are combinational from the shadow tags and current ID inputs;
//          shadow tags and stall_cnt update on the rising clk edge.
// Backpressure: mem_ready low during a MEM load/store freezes every stage; the tags hold.
// Optional feature: define HZ_ID_FWD_EN to enable ID-stage forwarding for branch operands,
//          which shortens ALU->branch stalls to one bubble.
module hazard_fwd_ctrl #(
    parameter int AW   = 5,
    parameter int NSRC = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 id_memwrite,
    input  logic                 id_branch,
    input  logic                 id_taken,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 bubble,
    output logic                 if_flush,
    output logic                 pipe_freeze,
    output logic [NSRC*2-1:0]    fwd_ex_sel,
    output logic [NSRC*2-1:0]    fwd_id_sel,
    output logic [CNTW-1:0]      stall_cnt
);

    // ------------------------------------------------------------------
    // Shadow destination tags for the EX, MEM and WB stages
    // ------------------------------------------------------------------
    logic                 ex_v;
    logic [AW-1:0]        ex_rd;
    logic [NSRC*AW-1:0]   ex_src;
    logic [NSRC-1:0]      ex_used;
    logic                 ex_rw;
    logic                 ex_mr;
    logic                 ex_mw;

    logic                 mem_v;
    logic [AW-1:0]        mem_rd;
    logic                 mem_rw;
    logic                 mem_mr;
    logic                 mem_mw;

    logic                 wb_v;
    logic [AW-1:0]        wb_rd;
    logic                 wb_rw;

    logic                 freeze;
    logic                 stall;
    logic [NSRC-1:0]      op_stall;
    logic                 id_rw_eff;

    // A stage producing register r: valid, writing, and r is not the hardwired zero.
    function automatic logic tag_match(input logic          v,
                                       input logic          rw,
                                       input logic [AW-1:0] rd,
                                       input logic [AW-1:0] r);
        return v & rw & (rd == r) & (r != '0);
    endfunction

    // Writes to r0 are folded into rw=0 at capture so they never look like producers.
    assign id_rw_eff = id_regwrite & (id_rd != '0);

    // Data memory still busy with the access sitting in MEM.
    assign freeze = mem_v & (mem_mr | mem_mw) & ~mem_ready;

    // ------------------------------------------------------------------
    // Per-operand hazard and forwarding decode
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NSRC; g++) begin : g_src
        logic [AW-1:0] id_s;
        logic [AW-1:0] ex_s;
        logic          ex_hit;
        logic          mem_hit;
        logic          br_mem_hit;
        logic          exs_mem_hit;
        logic          exs_wb_hit;

        assign id_s = id_src[g*AW +: AW];
        assign ex_s = ex_src[g*AW +: AW];

        // Producers of the ID operand that are still in flight.
        assign ex_hit  = tag_match(ex_v,  ex_rw,  ex_rd,  id_s);
        assign mem_hit = tag_match(mem_v, mem_rw, mem_rd, id_s);

        // Producers of the operand of the instruction now in EX.
        assign exs_mem_hit = tag_match(mem_v, mem_rw, mem_rd, ex_s);
        assign exs_wb_hit  = tag_match(wb_v,  wb_rw,  wb_rd,  ex_s);

`ifdef HZ_ID_FWD_EN
        logic id_wb_hit;
        assign id_wb_hit = tag_match(wb_v, wb_rw, wb_rd, id_s);

        // With ID forwarding only a load in MEM is too late for the branch compare.
        assign br_mem_hit = mem_hit & mem_mr;

        // ID branch operand select: MEM/WB result ahead of the regfile, MEM first.
        assign fwd_id_sel[g*2 +: 2] = (id_src_used[g] & mem_hit & ~mem_mr) ? 2'b01 :
                                      id_wb_hit                            ? 2'b10 :
                                                                             2'b00;
`else
        // Without ID forwarding any MEM producer must reach the regfile first.
        assign br_mem_hit = mem_hit;
        assign fwd_id_sel[g*2 +: 2] = 2'b00;
`endif

        // Load-use in EX, or an in-flight producer of a branch operand.
        assign op_stall[g] = id_src_used[g] &
                             ((ex_hit & ex_mr) | (id_branch & (ex_hit | br_mem_hit)));

        // EX operand select: MEM result (if not a load) beats WB result.
        assign fwd_ex_sel[g*2 +: 2] = (ex_used[g] & exs_mem_hit & ~mem_mr) ? 2'b01 :
                                      exs_wb_hit                           ? 2'b10 :
                                                                             2'b00;
    end

    assign stall = id_valid & (|op_stall);

    // ------------------------------------------------------------------
    // Pipeline control outputs: freeze beats stall, stall beats flush
    // ------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        bubble      = 1'b0;
        if_flush    = 1'b0;
        pipe_freeze = 1'b0;
        if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            bubble      = 1'b1;
        end else if (id_valid & id_taken) begin
            if_flush    = 1'b1;
        end
    end

    // Shadow pipeline advance; a stalled ID slot enters EX as an invalid bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v    <= 1'b0;
            ex_rd   <= '0;
            ex_src  <= '0;
            ex_used <= '0;
            ex_rw   <= 1'b0;
            ex_mr   <= 1'b0;
            ex_mw   <= 1'b0;
            mem_v   <= 1'b0;
            mem_rd  <= '0;
            mem_rw  <= 1'b0;
            mem_mr  <= 1'b0;
            mem_mw  <= 1'b0;
            wb_v    <= 1'b0;
            wb_rd   <= '0;
            wb_rw   <= 1'b0;
        end else if (!freeze) begin
            ex_v    <= id_valid & ~stall;
            ex_rd   <= id_rd;
            ex_src  <= id_src;
            ex_used <= id_src_used;
            ex_rw   <= id_rw_eff;
            ex_mr   <= id_memread;
            ex_mw   <= id_memwrite;
            mem_v   <= ex_v;
            mem_rd  <= ex_rd;
            mem_rw  <= ex_rw;
            mem_mr  <= ex_mr;
            mem_mw  <= ex_mw;
            wb_v    <= mem_v;
            wb_rd   <= mem_rd;
            wb_rw   <= mem_rw;
        end
    end

    // Saturating count of cycles lost to stalls or memory freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((stall | freeze) && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
    localparam int AW   = 5;
    localparam int NSRC = 2;
    localparam int CNTW = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [NSRC*AW-1:0]  id_src;
    logic [NSRC-1:0]     id_src_used;
    logic [AW-1:0]       id_rd;
    logic                id_regwrite, id_memread, id_memwrite, id_branch, id_taken;
    logic                mem_ready;

    logic                pc_write, ifid_write, bubble, if_flush, pipe_freeze;
    logic [NSRC*2-1:0]   fwd_ex_sel, fwd_id_sel;
    logic [CNTW-1:0]     stall_cnt;

    logic                s_pc_write, s_ifid_write, s_bubble, s_if_flush, s_pipe_freeze;
    logic [NSRC*2-1:0]   s_fwd_ex_sel, s_fwd_id_sel;
    logic [3:0]          s_stall_cnt;

    logic [4:0]          ctl;
    assign ctl = {pc_write, ifid_write, bubble, if_flush, pipe_freeze};

    int checks = 0;
    int errors = 0;
    logic [CNTW-1:0] exp_cnt;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.AW(AW), .NSRC(NSRC), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_taken(id_taken), .mem_ready(mem_ready), .pc_write(pc_write),
        .ifid_write(ifid_write), .bubble(bubble), .if_flush(if_flush),
        .pipe_freeze(pipe_freeze), .fwd_ex_sel(fwd_ex_sel), .fwd_id_sel(fwd_id_sel),
        .stall_cnt(stall_cnt)
    );

    hazard_fwd_ctrl #(.AW(AW), .NSRC(NSRC), .CNTW(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_taken(id_taken), .mem_ready(mem_ready), .pc_write(s_pc_write),
        .ifid_write(s_ifid_write), .bubble(s_bubble), .if_flush(s_if_flush),
        .pipe_freeze(s_pipe_freeze), .fwd_ex_sel(s_fwd_ex_sel), .fwd_id_sel(s_fwd_id_sel),
        .stall_cnt(s_stall_cnt)
    );

    // ctl bits: {pc_write, ifid_write, bubble, if_flush, pipe_freeze}
    task automatic chk_ctl(input string tag, input logic [4:0] e);
        checks++;
        assert (ctl === e) else begin
            errors++;
            $error("FAIL %s ctl: observed %b expected %b", tag, ctl, e);
        end
    endtask

    task automatic chk_ex(input string tag, input logic [3:0] e);
        checks++;
        assert (fwd_ex_sel === e) else begin
            errors++;
            $error("FAIL %s fwd_ex_sel: observed %b expected %b", tag, fwd_ex_sel, e);
        end
    endtask

    task automatic chk_id(input string tag, input logic [3:0] e);
        checks++;
        assert (fwd_id_sel === e) else begin
            errors++;
            $error("FAIL %s fwd_id_sel: observed %b expected %b", tag, fwd_id_sel, e);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] e);
        checks++;
        assert (stall_cnt === e) else begin
            errors++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, e);
        end
    endtask

    task automatic chk_scnt(input string tag, input logic [3:0] e);
        checks++;
        assert (s_stall_cnt === e) else begin
            errors++;
            $error("FAIL %s sat stall_cnt: observed %0d expected %0d", tag, s_stall_cnt, e);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] used, input logic [AW-1:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic br, input logic tk);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
        id_branch   = br;
        id_taken    = tk;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic alu(input logic [AW-1:0] rd, input logic [AW-1:0] s0, input logic [AW-1:0] s1);
        drive(1'b1, s0, s1, 2'b11, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic load(input logic [AW-1:0] rd, input logic [AW-1:0] s0);
        drive(1'b1, s0, 5'd0, 2'b01, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic beq(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic tk);
        drive(1'b1, s0, s1, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, tk);
    endtask
    task automatic jump();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        mem_ready = 1'b1;
        idle();
        #1;
        chk_ctl("reset", 5'b11000);
        chk_cnt("reset", 16'd0);
        chk_ex("reset", 4'b0000);
        chk_id("reset", 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 16'd0;

        // ---------------- load-use: lw r8; add r9,r8,r2 ----------------
        load(5'd8, 5'd1); #1;
        chk_ctl("lu_lw", 5'b11000);
        tick();
        alu(5'd9, 5'd8, 5'd2); #1;
        chk_ctl("lu_stall", 5'b00100);
        chk_cnt("lu_stall", exp_cnt);
        tick(); exp_cnt = exp_cnt + 16'd1;
        #1;
        chk_ctl("lu_release", 5'b11000);
        tick();
        idle(); #1;
        chk_ex("lu_fwd_wb", 4'b0010);
        chk_cnt("lu_cnt", exp_cnt);
        tick();

        // ---------------- ALU chain: add r3; sub r3; or r3 ----------------
        alu(5'd3, 5'd1, 5'd2); #1;
        chk_ctl("alu_add", 5'b11000);
        tick();
        alu(5'd10, 5'd3, 5'd4); #1;
        chk_ctl("alu_sub_nostall", 5'b11000);
        tick();
        alu(5'd11, 5'd3, 5'd5); #1;
        chk_ctl("alu_or_nostall", 5'b11000);
        chk_ex("alu_sub_fwd_mem", 4'b0001);
        tick();
        idle(); #1;
        chk_ex("alu_or_fwd_wb", 4'b0010);
        tick();

        // ---------------- branch after ALU: add r4; beq r4,r5 taken ----------------
        alu(5'd4, 5'd1, 5'd2); #1;
        tick();
        beq(5'd4, 5'd5, 1'b1); #1;
        chk_ctl("br_stall1", 5'b00100);
        tick(); exp_cnt = exp_cnt + 16'd1;
        #1;
`ifdef HZ_ID_FWD_EN
        chk_ctl("br_flush", 5'b11010);
        chk_id("br_fwd_id", 4'b0001);
        tick();
`else
        chk_ctl("br_stall2", 5'b00100);
        chk_id("br_fwd_id_off", 4'b0000);
        tick(); exp_cnt = exp_cnt + 16'd1;
        #1;
        chk_ctl("br_flush", 5'b11010);
        chk_id("br_fwd_id_off2", 4'b0000);
        tick();
`endif
        idle(); #1;
        chk_ctl("br_after", 5'b11000);
        chk_cnt("br_cnt", exp_cnt);
        tick(); tick(); tick();

        // ---------------- memory wait: lw in MEM, mem_ready low 3 cycles ----------------
        alu(5'd9, 5'd1, 5'd2); #1;
        tick();
        load(5'd6, 5'd1); #1;
        tick();
        alu(5'd7, 5'd9, 5'd2); #1;
        chk_ctl("mw_add_nostall", 5'b11000);
        tick();
        mem_ready = 1'b0;
        jump(); #1;
        for (int k = 0; k < 3; k++) begin
            chk_ctl("mw_freeze", 5'b00001);
            chk_ex("mw_tags_hold", 4'b0010);
            chk_cnt("mw_cnt", exp_cnt);
            tick(); exp_cnt = exp_cnt + 16'd1;
        end
        mem_ready = 1'b1; #1;
        chk_ctl("mw_release_flush", 5'b11010);
        chk_ex("mw_release_fwd", 4'b0010);
        chk_cnt("mw_cnt_end", exp_cnt);
        tick();
        idle(); #1;
        chk_ctl("mw_after", 5'b11000);
        tick(); tick(); tick();

        // ---------------- register 0: lw r0; add r5,r0,r0 ----------------
        load(5'd0, 5'd1); #1;
        tick();
        alu(5'd5, 5'd0, 5'd0); #1;
        chk_ctl("r0_nostall", 5'b11000);
        tick();
        idle(); #1;
        chk_ex("r0_fwd_none", 4'b0000);
        chk_ctl("r0_nofreeze", 5'b11000);
        tick(); tick(); tick();

        // ---------------- reset mid-stall ----------------
        load(5'd8, 5'd1); #1;
        tick();
        alu(5'd9, 5'd8, 5'd2); #1;
        chk_ctl("rs_stall", 5'b00100);
        chk_cnt("rs_cnt_before", exp_cnt);
        rst = 1'b1; #1;
        chk_ctl("rs_cleared", 5'b11000);
        chk_cnt("rs_cnt_zero", 16'd0);
        chk_scnt("rs_sat_zero", 4'd0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // ---------------- saturation (CNTW=4) and reset during freeze ----------------
        load(5'd6, 5'd1); #1;
        tick();
        idle(); #1;
        tick();
        mem_ready = 1'b0; #1;
        chk_ctl("sat_freeze", 5'b00001);
        for (int k = 0; k < 15; k++) tick();
        chk_scnt("sat_15", 4'd15);
        chk_cnt("cnt_15", 16'd15);
        for (int k = 0; k < 5; k++) tick();
        chk_scnt("sat_20", 4'd15);
        chk_cnt("cnt_20", 16'd20);
        chk_ctl("sat_still_frozen", 5'b00001);
        rst = 1'b1; #1;
        chk_ctl("rst_in_freeze", 5'b11000);
        chk_cnt("rst_in_freeze", 16'd0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
